uart_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one uart_tx byte transmitter among NUM_REQ requesters.

---
 rtl/uart_tx_sched_pkg.sv | 20 ++
 rtl/uart_tx_sched_if.sv | 24 ++
 rtl/uart_tx_sched_rr_arbiter.sv | 28 ++
 rtl/uart_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and sizing helpers for the uart_tx scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } sched_state_e;

  // Inter-frame gap counter width; GAP_CLKS tops out at 255.
  localparam int GAP_W = 8;

  // Width of a requester index (at least one bit).
  function automatic int req_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side and uart_tx-side handshake bundle around the scheduler.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      req_ack;
  logic                    send_trig;
  logic [7:0]              send_data;
  logic                    tx_bsy;

  // Scheduler side.
  modport slave (
    input  req, req_data, req_last, tx_bsy,
    output req_ack, send_trig, send_data
  );

  // Requesters plus uart_tx side.
  modport master (
    output req, req_data, req_last, tx_bsy,
    input  req_ack, send_trig, send_data
  );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at/after the rr pointer, wrapping.
module uart_tx_sched_rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int REQ_W   = req_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [REQ_W-1:0]   rr_i,
  output logic               gnt_vld_o,
  output logic [REQ_W-1:0]   gnt_id_o
);
  logic [REQ_W-1:0] idx;

  // Scan farthest offset first so the nearest set bit to rr wins.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_id_o  = '0;
    idx       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = REQ_W'((int'(rr_i) + i) % NUM_REQ);
      if (req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_id_o  = idx;
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler: locks one requester onto the shared uart_tx for a whole packet.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int GAP_CLKS = 0,
  parameter  int LOCK_TMO = 255,
  localparam int REQ_W    = req_w(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_sched_if.slave   bus,
  output logic [REQ_W-1:0] grant_id_o,
  output logic             locked_o,
  output logic             stall_err_o
);
  localparam int TMO_W = $clog2(LOCK_TMO + 1);

  sched_state_e       state_q, state_d;
  logic [REQ_W-1:0]   grant_q, grant_d;
  logic [REQ_W-1:0]   rr_q, rr_d, rr_nxt;
  logic [REQ_W-1:0]   pick_id;
  logic               pick_vld;
  logic               locked_q, locked_d;
  logic               last_q, last_d;
  logic               ws_q, ws_d;
  logic               trig_q, trig_d;
  logic               stall_q, stall_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         data_q, data_d;
  logic               exit_now;

  uart_tx_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (bus.req),
    .rr_i      (rr_q),
    .gnt_vld_o (pick_vld),
    .gnt_id_o  (pick_id)
  );

  // Pointer wraps modulo NUM_REQ, not modulo 2^REQ_W.
  assign rr_nxt = (grant_q == REQ_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    locked_d = locked_q;
    last_d   = last_q;
    ws_d     = ws_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    data_d   = data_q;
    ack_d    = '0;
    trig_d   = 1'b0;
    stall_d  = 1'b0;
    exit_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d  = pick_id;
          locked_d = 1'b1;
          tmo_d    = '0;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // A frame still on the wire is not ours to time out against.
        if (bus.tx_bsy) begin
          state_d = S_LAUNCH;
        end else if (bus.req[grant_q]) begin
          trig_d         = 1'b1;
          data_d         = bus.req_data[grant_q];
          ack_d[grant_q] = 1'b1;
          last_d         = bus.req_last[grant_q];
          ws_d           = 1'b0;
          state_d        = S_WAIT_START;
        end else if (tmo_q == TMO_W'(LOCK_TMO - 1)) begin
          locked_d = 1'b0;
          rr_d     = rr_nxt;
          state_d  = S_IDLE;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_START: begin
        // The acked byte is not resent on a stall; it is lost.
        if (bus.tx_bsy) begin
          state_d = S_WAIT_DONE;
        end else if (ws_q) begin
          stall_d = 1'b1;
          tmo_d   = '0;
          state_d = S_LAUNCH;
        end else begin
          ws_d = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_bsy) begin
          if (GAP_CLKS > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            exit_now = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CLKS - 1)) exit_now = 1'b1;
        else                               gap_d    = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (exit_now) begin
      if (last_q) begin
        locked_d = 1'b0;
        rr_d     = rr_nxt;
        state_d  = S_IDLE;
      end else begin
        tmo_d   = '0;
        state_d = S_LAUNCH;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      locked_q <= 1'b0;
      last_q   <= 1'b0;
      ws_q     <= 1'b0;
      tmo_q    <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      ack_q    <= '0;
      trig_q   <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      locked_q <= locked_d;
      last_q   <= last_d;
      ws_q     <= ws_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      trig_q   <= trig_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.send_trig = trig_q;
  assign bus.send_data = data_q;
  assign grant_id_o    = grant_q;
  assign locked_o      = locked_q;
  assign stall_err_o   = stall_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a behavioural uart_tx (27 clk/bit, 10 bits/frame).
module tb_uart_tx_sched;
  localparam int NREQ  = 4;
  localparam int GAP   = 5;
  localparam int TMO   = 16;
  localparam int FRAME = 270;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic       clk, rst_n, stall_mode, u_bsy, u_pend;
  logic [1:0] grant_id;
  logic       locked, stall_err;
  int         u_cnt, cyc, n_cmp, n_err, t0;
  exp_t       exp_q[$];
  logic [8:0] rq[NREQ][$];

  uart_tx_sched_if #(.NUM_REQ(NREQ)) bus();

  uart_tx_sched #(.NUM_REQ(NREQ), .GAP_CLKS(GAP), .LOCK_TMO(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_id_o  (grant_id),
    .locked_o    (locked),
    .stall_err_o (stall_err)
  );

  assign bus.tx_bsy = u_bsy & ~stall_mode;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input int id, input logic [7:0] d, input logic last);
    exp_t e;
    e.id   = id;
    e.data = d;
    rq[id].push_back({last, d});
    exp_q.push_back(e);
  endtask

  // which: 0 tx_bsy, 1 locked, 2 send_trig, 3 scoreboard empty
  task automatic wait_sig(input int which, input logic val, input int max, input string nm);
    logic v;
    bit   hit;
    hit = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      case (which)
        0:       v = bus.tx_bsy;
        1:       v = locked;
        2:       v = bus.send_trig;
        default: v = (exp_q.size() == 0);
      endcase
      if (v == val) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL %s: condition not reached within %0d clks", nm, max);
    end
  endtask

  // uart_tx model: trig seen after edge k -> busy after edge k+1 for FRAME clks.
  initial begin
    u_bsy = 1'b0; u_pend = 1'b0; u_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        u_bsy = 1'b0; u_pend = 1'b0; u_cnt = 0;
      end else begin
        if (u_pend) begin
          u_bsy = 1'b1; u_cnt = 0; u_pend = 1'b0;
        end else if (u_bsy) begin
          u_cnt++;
          if (u_cnt == FRAME) u_bsy = 1'b0;
        end
        if (bus.send_trig && !u_bsy) u_pend = 1'b1;
      end
    end
  end

  // Requesters: present queue head, advance on ack.
  initial begin
    bus.req = '0; bus.req_data = '0; bus.req_last = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        bus.req[i]      = (rq[i].size() > 0);
        bus.req_data[i] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
        bus.req_last[i] = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
      end
    end
  end

  // Monitor: every launched byte must match the scoreboard head.
  initial begin
    exp_t       e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.send_trig) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL trig_unexpected: data 0x%0h id %0d, nothing expected", bus.send_data, grant_id);
          end else begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e.id;
            chk("trig_id", 32'(grant_id), 32'(e.id));
            chk("trig_data", 32'(bus.send_data), 32'(e.data));
            chk("trig_ack", 32'(bus.req_ack), 32'(oh));
          end
        end else if (bus.req_ack != '0) begin
          n_cmp++; n_err++;
          $display("FAIL ack_without_trig: req_ack 0x%0h", bus.req_ack);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; rst_n = 1'b0; stall_mode = 1'b0; t0 = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({bus.req_ack, bus.send_trig, bus.send_data, grant_id, locked, stall_err}), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_activity", 32'({locked, bus.send_trig}), 32'h0);

    // Single byte with latency: req rises at edge k.
    @(negedge clk); issue(1, 8'hA5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("lat_grant", 32'({locked, grant_id}), 32'b101);
    chk("lat_no_early_trig", 32'(bus.send_trig), 32'h0);
    @(negedge clk); chk("lat_trig", 32'(bus.send_trig), 32'h1);
    @(negedge clk); chk("lat_bsy", 32'(bus.tx_bsy), 32'h1);
    wait_sig(1, 1'b0, 400, "single_release");

    // Packet lock: req0 three bytes, req2 raised mid-packet; also inter-frame gap.
    @(negedge clk); issue(0, 8'h01, 1'b0); issue(0, 8'h02, 1'b0); issue(0, 8'h03, 1'b1);
    wait_sig(2, 1'b1, 20, "pkt_first_trig");
    issue(2, 8'h77, 1'b1);
    wait_sig(0, 1'b1, 10, "pkt_bsy_rise");
    wait_sig(0, 1'b0, 400, "pkt_bsy_fall");
    t0 = cyc;
    wait_sig(2, 1'b1, 40, "pkt_second_trig");
    chk("gap_spacing", 32'(cyc - t0), 32'(GAP + 2));
    wait_sig(3, 1'b1, 1500, "pkt_drain");
    wait_sig(1, 1'b0, 400, "pkt_release");

    // Reset in the middle of a packet.
    @(negedge clk); issue(1, 8'h21, 1'b0); issue(1, 8'h22, 1'b1);
    wait_sig(0, 1'b1, 20, "rst_bsy_rise");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    #1;
    chk("rst_mid_outs", 32'({bus.req_ack, bus.send_trig, bus.send_data, grant_id, locked, stall_err}), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Round robin from a fresh pointer: 0,1,2,3 then wrap to 0.
    @(negedge clk);
    issue(0, 8'hA0, 1'b1); issue(1, 8'hB1, 1'b1); issue(2, 8'hC2, 1'b1);
    issue(3, 8'hD3, 1'b1); issue(0, 8'hE0, 1'b1);
    wait_sig(3, 1'b1, 2000, "rr_drain");
    wait_sig(1, 1'b0, 400, "rr_release");

    // Lock timeout: owner 1 drops req after a non-last byte; req3 waits.
    @(negedge clk); issue(1, 8'h11, 1'b0);
    wait_sig(2, 1'b1, 20, "tmo_trig");
    issue(3, 8'h33, 1'b1);
    wait_sig(0, 1'b1, 10, "tmo_bsy_rise");
    wait_sig(0, 1'b0, 400, "tmo_bsy_fall");
    t0 = cyc;
    wait_sig(1, 1'b0, 100, "tmo_release");
    chk("tmo_release_cyc", 32'(cyc - t0), 32'(1 + GAP + TMO));
    wait_sig(3, 1'b1, 20, "tmo_req3_served");
    wait_sig(1, 1'b0, 400, "tmo_req3_done");

    // Stall: tx_bsy never rises.
    @(negedge clk); stall_mode = 1'b1; issue(2, 8'h5A, 1'b1);
    wait_sig(2, 1'b1, 20, "stall_trig");
    t0 = cyc;
    @(negedge clk); chk("stall_early", 32'(stall_err), 32'h0);
    @(negedge clk); chk("stall_pulse", 32'(stall_err), 32'h1);
    @(negedge clk); chk("stall_one_clk", 32'(stall_err), 32'h0);
    wait_sig(1, 1'b0, 40, "stall_release");
    chk("stall_release_cyc", 32'(cyc - t0), 32'(2 + TMO));

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
